load_store_unit: RTL and testbench

//  Multi-cycle load/store unit directly downstream of the execute ALU: takes alu_result as the

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store unit that sits after the execute ALU. The ALU result is
//   taken as the effective address. The unit checks the access for legality and
//   alignment, and runs one word-addressed memory transaction with a req/gnt/rvalid
//   handshake. Load data is then aligned and extended for register writeback.
//   Every output is registered except req_ready.
//
// Ports
//   clk, rst     single clock; synchronous active-high reset
//   req_valid    memory instruction presented (held until resp_valid)
//   req_ready    unit idle and able to accept this cycle
//   is_load      LB/LH/LW/LBU/LHU
//   is_store     SB/SH/SW
//   funct3       [1:0] size (00 B, 01 H, 10 W), [2] unsigned (loads)
//   addr         effective address
//   store_data   rs2 value
//   resp_valid   one-cycle completion/rejection pulse
//   load_data    aligned, extended load result (0 after stores and errors)
//   misaligned   with resp_valid: address not aligned to access size
//   illegal      with resp_valid: bad funct3, or both is_load and is_store set
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   memory request side
//   mem_gnt      memory accepts the request this cycle
//   mem_rvalid   read data valid
//   mem_rdata    read word
module load_store_unit #(
  parameter int REGF_WIDTH = 32  // byte-lane logic assumes 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [REGF_WIDTH-1:0] addr,
  input  logic [REGF_WIDTH-1:0] store_data,
  output logic                  resp_valid,
  output logic [REGF_WIDTH-1:0] load_data,
  output logic                  misaligned,
  output logic                  illegal,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [REGF_WIDTH-1:0] mem_addr,
  output logic [REGF_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [REGF_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t     state;
  logic [1:0] lane;      // addr[1:0] of the accepted access, used to pick load bytes
  logic [2:0] f3;        // funct3 of the accepted access
  logic       dec_illegal;
  logic       dec_misaligned;

  // Replicate store data across the byte lanes so the strobes alone pick the target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Select the addressed byte/half out of the read word, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] fn, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = rd[{lo[1], 4'b0000} +: 16];
    case (fn)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  always_comb begin
    dec_illegal = is_load && is_store;
    if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
      dec_illegal = 1'b1;
    if (is_store && (funct3[2] || funct3[1:0] == 2'b11))
      dec_illegal = 1'b1;
    dec_misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  end

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      load_data  <= '0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= 4'd0;
      lane       <= 2'd0;
      f3         <= 3'd0;
    end else begin
      case (state)
        // Accept: either reject straight to RESP or launch the memory request.
        IDLE: begin
          if (req_valid && (is_load || is_store)) begin
            if (dec_illegal || dec_misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              illegal    <= dec_illegal;
              misaligned <= !dec_illegal && dec_misaligned;
              load_data  <= '0;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[REGF_WIDTH-1:2], 2'b00};
              mem_wdata <= is_store ? store_lanes(funct3[1:0], store_data) : '0;
              mem_wstrb <= is_store ? store_strb(funct3[1:0], addr[1:0]) : 4'd0;
              lane      <= addr[1:0];
              f3        <= funct3;
            end
          end
        end
        // Request held stable until granted.
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              load_data  <= '0;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        // Read data return.
        WAIT_R: begin
          if (mem_rvalid) begin
            load_data  <= load_extend(f3, lane, mem_rdata);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        // Single-cycle response; flags drop on the way out.
        RESP: begin
          resp_valid <= 1'b0;
          misaligned <= 1'b0;
          illegal    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit #(.REGF_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .resp_valid(resp_valid), .load_data(load_data),
    .misaligned(misaligned), .illegal(illegal), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          gdly;
    logic [31:0] e_ld;
    logic        e_mis;
    logic        e_ill;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    int          e_lat;
  } vec_t;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        ill;
    int          lat;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rd, input int gdly,
                              input logic [31:0] e_ld, input logic e_mis, input logic e_ill,
                              input logic [31:0] e_maddr, input logic [31:0] e_wdata,
                              input logic [3:0] e_wstrb, input int e_lat);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd; v.gdly = gdly;
    v.e_ld = e_ld; v.e_mis = e_mis; v.e_ill = e_ill; v.e_maddr = e_maddr;
    v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_lat = e_lat;
    return v;
  endfunction

  // Drive one request, act as the memory, and score the response.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    int   req_cycles;
    bit   done;
    bit   bad;
    bit   rv_next;
    exp_t e;
    exp_t got;
    @(posedge clk); #1;
    chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
    addr = v.a; store_data = v.sd;
    e.ld = v.e_ld; e.mis = v.e_mis; e.ill = v.e_ill; e.lat = v.e_lat;
    sb.push_back(e);
    cyc = 0; req_cycles = 0; done = 0; bad = 0; rv_next = 0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      if (rv_next) begin
        mem_rvalid = 1'b1; mem_rdata = v.rd; rv_next = 0;
      end
      if (mem_req) begin
        if (mem_addr !== v.e_maddr || mem_we !== v.st || mem_wstrb !== v.e_wstrb ||
            mem_wdata !== v.e_wdata) bad = 1;
        if (req_cycles == v.gdly) begin
          mem_gnt = 1'b1;
          if (v.ld) rv_next = 1;
        end
        req_cycles++;
      end
      if (resp_valid) begin
        done = 1;
        if (sb.size() == 0) begin
          chk($sformatf("v%0d unexpected resp", idx), 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          chk($sformatf("v%0d latency", idx), cyc, got.lat);
          chk($sformatf("v%0d load_data", idx), load_data, got.ld);
          chk($sformatf("v%0d misaligned", idx), {31'd0, misaligned}, {31'd0, got.mis});
          chk($sformatf("v%0d illegal", idx), {31'd0, illegal}, {31'd0, got.ill});
        end
      end
    end
    if (!done) begin
      chk($sformatf("v%0d resp timeout", idx), 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (v.e_mis || v.e_ill) begin
      chk($sformatf("v%0d mem_req cycles", idx), req_cycles, 0);
    end else begin
      chk($sformatf("v%0d mem_req cycles", idx), req_cycles, v.gdly + 1);
      chk($sformatf("v%0d mem fields", idx), {31'd0, bad}, 32'd0);
    end
  endtask

  initial begin
    //      ld st  f3      addr         sd            rdata       gd  e_ld         mis ill  maddr        wdata         wstrb    lat
    vt.push_back(mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 32'h0,        0, 0, 32'h100, 32'hDEADBEEF, 4'b1111, 2));
    vt.push_back(mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 32'hFFFFFF80, 0, 0, 32'h100, 32'h0,        4'b0000, 3));
    vt.push_back(mk(0, 1, 3'b001, 32'h22,  32'h0000ABCD, 32'h0,        0, 32'h0,        0, 0, 32'h20,  32'hABCDABCD, 4'b1100, 2));
    vt.push_back(mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 32'h00000080, 0, 0, 32'h100, 32'h0,        4'b0000, 3));
    vt.push_back(mk(1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h0,   32'h0,        4'b0000, 1));
    vt.push_back(mk(1, 0, 3'b001, 32'h10,  32'h0,        32'h1234F00D, 5, 32'hFFFFF00D, 0, 0, 32'h10,  32'h0,        4'b0000, 8));
    vt.push_back(mk(0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 32'h0,        0, 0, 32'h100, 32'hA5A5A5A5, 4'b0010, 2));
    vt.push_back(mk(1, 0, 3'b101, 32'h12,  32'h0,        32'h87654321, 0, 32'h00008765, 0, 0, 32'h10,  32'h0,        4'b0000, 3));
    vt.push_back(mk(1, 0, 3'b001, 32'h13,  32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h0,   32'h0,        4'b0000, 1));
    vt.push_back(mk(1, 0, 3'b011, 32'h40,  32'h0,        32'h0,        0, 32'h0,        0, 1, 32'h0,   32'h0,        4'b0000, 1));
    vt.push_back(mk(0, 1, 3'b100, 32'h40,  32'h0,        32'h0,        0, 32'h0,        0, 1, 32'h0,   32'h0,        4'b0000, 1));
    vt.push_back(mk(1, 1, 3'b010, 32'h101, 32'h0,        32'h0,        0, 32'h0,        0, 1, 32'h0,   32'h0,        4'b0000, 1));
    vt.push_back(mk(0, 1, 3'b010, 32'h102, 32'h11223344, 32'h0,        0, 32'h0,        1, 0, 32'h0,   32'h0,        4'b0000, 1));
    vt.push_back(mk(1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 2, 32'h0000007F, 0, 0, 32'h100, 32'h0,        4'b0000, 5));
    vt.push_back(mk(0, 1, 3'b001, 32'h30,  32'hFFFF1357, 32'h0,        3, 32'h0,        0, 0, 32'h30,  32'h13571357, 4'b0011, 5));
    vt.push_back(mk(1, 0, 3'b010, 32'h200, 32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0, 32'h200, 32'h0,        4'b0000, 3));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst flags", {30'd0, misaligned, illegal}, 32'd0);
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i], i);

    // req_valid without is_load/is_store must be ignored; rvalid in IDLE is dropped.
    @(posedge clk); #1;
    req_valid = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("noop%0d idle", k), {30'd0, req_ready, mem_req}, 32'd2);
      chk($sformatf("noop%0d resp_valid", k), {31'd0, resp_valid}, 32'd0);
    end
    chk("idle rvalid load_data held", load_data, 32'hCAFEF00D);
    req_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    // Reset while waiting for read data; late rvalid must be dropped.
    @(posedge clk); #1;
    req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    chk("rstw mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rstw in WAIT_R", {30'd0, req_ready, mem_req}, 32'd0);
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstw%0d resp_valid", k), {31'd0, resp_valid}, 32'd0);
      chk($sformatf("rstw%0d req_ready", k), {31'd0, req_ready}, 32'd1);
      chk($sformatf("rstw%0d load_data", k), load_data, 32'd0);
      @(posedge clk); #1;
    end

    chk("scoreboard empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
